ota_pdm_readout: RTL and testbench

Digital readout for the NOR-based digital OTA's 1-bit comparator output, inside the tt_um_digiOTA_NOR_1 user project. It synchronizes the asynchronous output bit and counts ones over a fixed window of 2^WIN_LOG2 clocks. The density result goes to the pin-mux logic through a valid/ready handshake, giving on-chip measurement of what the testbench currently observes from outside.

---
 rtl/ota_readout_pkg.sv | 27 ++
 rtl/ota_pdm_readout_sync.sv | 28 ++
 rtl/ota_pdm_readout.sv | 129 ++++++++++++
 tb/tb_ota_pdm_readout.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/ota_readout_pkg.sv
// Shared types and width helpers for the OTA pulse-density readout.
package ota_readout_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        ACC    = 2'd2
    } state_e;

    localparam int WIN_LOG2_DEF = 8;
    localparam int N            = 1 << WIN_LOG2_DEF;
    localparam int CNT_W        = WIN_LOG2_DEF + 1;

    // Result width: one extra bit so an all-ones window reports N without wrapping.
    function automatic int cnt_w(input int log2n);
        return log2n + 1;
    endfunction

    function automatic int win_cnt_w(input int log2n);
        return (log2n < 1) ? 1 : log2n;
    endfunction

    function automatic int settle_cnt_w(input int stages);
        return ($clog2(stages) < 1) ? 1 : $clog2(stages);
    endfunction

endpackage

// File: rtl/ota_pdm_readout_sync.sv
// Reset-clearable multi-flop synchronizer for the asynchronous comparator bit.
module ota_sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], din};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign dout = sync_q[STAGES-1];

endmodule

// File: rtl/ota_pdm_readout.sv
// Counts ones of the synchronized OTA bit over 2^WIN_LOG2 clocks and hands the
// density to the pin mux through a valid/ready register with sticky overrun.
module ota_pdm_readout
    import ota_readout_pkg::*;
#(
    parameter int WIN_LOG2    = WIN_LOG2_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    input  logic                din,
    input  logic                start,
    input  logic                continuous,
    output logic [WIN_LOG2:0]   res_data,
    output logic                res_valid,
    input  logic                res_ready,
    output logic                overrun,
    output logic                busy
);

    localparam int RES_W = cnt_w(WIN_LOG2);
    localparam int WC_W  = win_cnt_w(WIN_LOG2);
    localparam int SC_W  = settle_cnt_w(SYNC_STAGES);

    logic             sync_bit;
    state_e           state_q, state_d;
    logic [SC_W-1:0]  settle_cnt_q, settle_cnt_d;
    logic [WC_W-1:0]  win_cnt_q, win_cnt_d;
    logic [RES_W-1:0] ones_q, ones_d;
    logic [RES_W-1:0] ones_sum;
    logic [RES_W-1:0] res_data_q, res_data_d;
    logic             res_valid_q, res_valid_d;
    logic             overrun_q, overrun_d;
    logic             load;

    ota_sync_bit #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (din),
        .dout (sync_bit)
    );

    // Includes the current cycle's bit so the final ACC cycle is counted.
    assign ones_sum = ones_q + RES_W'(sync_bit);

    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        win_cnt_d    = win_cnt_q;
        ones_d       = ones_q;
        res_data_d   = res_data_q;
        res_valid_d  = res_valid_q;
        overrun_d    = overrun_q;
        load         = 1'b0;

        if (ena) begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d      = SETTLE;
                        settle_cnt_d = '0;
                        overrun_d    = 1'b0;
                    end
                end
                SETTLE: begin
                    win_cnt_d = '0;
                    ones_d    = '0;
                    if (settle_cnt_q == SC_W'(SYNC_STAGES - 1)) begin
                        state_d = ACC;
                    end else begin
                        settle_cnt_d = settle_cnt_q + SC_W'(1);
                    end
                end
                ACC: begin
                    win_cnt_d = win_cnt_q + WC_W'(1);
                    if (win_cnt_q == WC_W'((1 << WIN_LOG2) - 1)) begin
                        load    = 1'b1;
                        ones_d  = '0;
                        win_cnt_d = '0;
                        state_d = continuous ? ACC : IDLE;
                    end else begin
                        ones_d = ones_sum;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // Newest result wins; overwriting an unaccepted one is flagged.
        if (load) begin
            res_data_d  = ones_sum;
            res_valid_d = 1'b1;
            if (res_valid_q && !res_ready) begin
                overrun_d = 1'b1;
            end
        end else if (res_valid_q && res_ready) begin
            res_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            settle_cnt_q <= '0;
            win_cnt_q    <= '0;
            ones_q       <= '0;
            res_data_q   <= '0;
            res_valid_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            win_cnt_q    <= win_cnt_d;
            ones_q       <= ones_d;
            res_data_q   <= res_data_d;
            res_valid_q  <= res_valid_d;
            overrun_q    <= overrun_d;
        end
    end

    assign res_data  = res_data_q;
    assign res_valid = res_valid_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_ota_pdm_readout.sv
// Directed bench for ota_pdm_readout with N=16, two-flop synchronizer.
module tb_ota_pdm_readout;

    localparam int WL = 4;
    localparam int SS = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ena;
    logic        din;
    logic        start;
    logic        continuous;
    logic [WL:0] res_data;
    logic        res_valid;
    logic        res_ready;
    logic        overrun;
    logic        busy;

    int          checks = 0;
    int          errors = 0;
    logic        toggle = 1'b0;
    logic [31:0] exp_q[$];

    ota_pdm_readout #(
        .WIN_LOG2   (WL),
        .SYNC_STAGES(SS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .din       (din),
        .start     (start),
        .continuous(continuous),
        .res_data  (res_data),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance n edges, sampling/driving 1ns after each edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (toggle) din = ~din;
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic chk_result(input string tag);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk(tag, 32'(res_data), e);
        end
    endtask

    task automatic accept();
        res_ready = 1'b1;
        step(1);
        res_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; ena = 1'b1; din = 1'b1; start = 1'b0;
        continuous = 1'b0; res_ready = 1'b0;
        step(3);
        chk("rst_data", 32'(res_data), 32'd0);
        chk("rst_valid", 32'(res_valid), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        step(2);

        // 1: all ones, result exactly N with no wrap
        exp_q.push_back(32'd16);
        do_start();
        chk("s1_busy", 32'(busy), 32'd1);
        step(17);
        chk("s1_valid_early", 32'(res_valid), 32'd0);
        step(1);
        chk("s1_valid", 32'(res_valid), 32'd1);
        chk("s1_busy_end", 32'(busy), 32'd0);
        chk_result("s1_data");
        accept();
        chk("s1_accepted", 32'(res_valid), 32'd0);

        // 2: all zeros, then alternating bits
        din = 1'b0;
        step(3);
        exp_q.push_back(32'd0);
        do_start();
        step(18);
        chk("s2a_valid", 32'(res_valid), 32'd1);
        chk_result("s2a_data");
        accept();
        toggle = 1'b1;
        exp_q.push_back(32'd8);
        do_start();
        step(18);
        chk("s2b_valid", 32'(res_valid), 32'd1);
        chk_result("s2b_data");
        toggle = 1'b0;
        accept();

        // 3: continuous windows without acceptance -> overrun
        din = 1'b1; continuous = 1'b1;
        step(3);
        exp_q.push_back(32'd16);
        exp_q.push_back(32'd0);
        do_start();
        step(16);
        din = 1'b0;
        step(2);
        chk("s3_valid_w1", 32'(res_valid), 32'd1);
        chk_result("s3_data_w1");
        chk("s3_overrun_w1", 32'(overrun), 32'd0);
        continuous = 1'b0;
        step(15);
        chk("s3_stable", 32'(res_data), 32'd16);
        chk("s3_busy_mid", 32'(busy), 32'd1);
        step(1);
        chk_result("s3_data_w2");
        chk("s3_overrun", 32'(overrun), 32'd1);
        chk("s3_valid_w2", 32'(res_valid), 32'd1);
        chk("s3_busy_end", 32'(busy), 32'd0);
        accept();
        chk("s3_overrun_sticky", 32'(overrun), 32'd1);
        exp_q.push_back(32'd0);
        do_start();
        chk("s3_overrun_clr", 32'(overrun), 32'd0);
        step(18);
        chk_result("s3_data_w3");
        chk("s3_overrun_w3", 32'(overrun), 32'd0);
        accept();

        // 4: acceptance on the same edge a new window loads
        din = 1'b1; continuous = 1'b1;
        step(3);
        exp_q.push_back(32'd16);
        exp_q.push_back(32'd8);
        do_start();
        step(16);
        din = 1'b0; toggle = 1'b1;
        step(2);
        chk_result("s4_data_w1");
        continuous = 1'b0;
        step(15);
        res_ready = 1'b1;
        step(1);
        res_ready = 1'b0;
        chk("s4_valid", 32'(res_valid), 32'd1);
        chk_result("s4_data_w2");
        chk("s4_overrun", 32'(overrun), 32'd0);
        toggle = 1'b0;
        accept();

        // 5: ena pause for 5 cycles mid-ACC, start while busy ignored
        din = 1'b1;
        step(3);
        exp_q.push_back(32'd16);
        do_start();
        step(5);
        ena = 1'b0;
        step(5);
        chk("s5_busy_paused", 32'(busy), 32'd1);
        ena = 1'b1;
        do_start();
        step(11);
        chk("s5_valid_early", 32'(res_valid), 32'd0);
        step(1);
        chk("s5_valid", 32'(res_valid), 32'd1);
        chk_result("s5_data");
        step(1);
        chk("s5_no_restart", 32'(busy), 32'd0);

        // 6: asynchronous reset mid-ACC with an unconsumed result pending
        do_start();
        step(9);
        chk("s6_pre_valid", 32'(res_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("s6_rst_data", 32'(res_data), 32'd0);
        chk("s6_rst_valid", 32'(res_valid), 32'd0);
        chk("s6_rst_busy", 32'(busy), 32'd0);
        chk("s6_rst_overrun", 32'(overrun), 32'd0);
        step(2);
        rst_n = 1'b1;
        step(1);
        exp_q.push_back(32'd16);
        do_start();
        step(17);
        chk("s6_valid_early", 32'(res_valid), 32'd0);
        step(1);
        chk("s6_valid", 32'(res_valid), 32'd1);
        chk_result("s6_data");

        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
